// File: rtl/player_motion_integrator.sv
// Per-player motion integrator: frame-tick position update, jump FSM, kick hold timer.
// Build option: define WRAP_X_EN to wrap x at the playfield edges instead of clamping.
module player_motion_integrator #(
    parameter int TICK_DIV   = 833333,
    parameter int SCREEN_W   = 640,
    parameter int SPRITE_W   = 32,
    parameter int GROUND_Y   = 368,
    parameter int START_X    = 304,
    parameter int JUMP_TICKS = 10,
    parameter int GRAVITY    = 5,
    parameter int KICK_TICKS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] dx,
    input  logic [10:0] dy,
    input  logic        kickon,
    output logic [10:0] px,
    output logic [10:0] py,
    output logic        on_ground,
    output logic        kick_active,
    output logic        frame_tick,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } jump_state_t;

    localparam int CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int RISE_W = $clog2(JUMP_TICKS + 1);
    localparam int KICK_W = $clog2(KICK_TICKS + 1);

    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TICK_DIV - 1);
    localparam logic [RISE_W-1:0]  RISE_MAX  = RISE_W'(JUMP_TICKS);
    localparam logic [KICK_W-1:0]  KICK_INIT = KICK_W'(KICK_TICKS);
    localparam logic signed [12:0] X_MAX     = 13'(SCREEN_W - SPRITE_W);
    localparam logic signed [12:0] Y_MAX     = 13'(GROUND_Y);
    localparam logic signed [10:0] GRAV      = 11'(GRAVITY);

    jump_state_t        r_state;
    logic [CNT_W-1:0]   r_tick_cnt;
    logic [RISE_W-1:0]  r_rise_cnt;
    logic [KICK_W-1:0]  r_kick_cnt;
    logic               r_kick_prev;
    logic [10:0]        r_px;
    logic [10:0]        r_py;
    logic               r_on_ground;
    logic               r_kick_active;
    logic               r_frame_tick;

    logic signed [12:0] w_x_sum;
    logic signed [12:0] w_y_sum;
    logic signed [10:0] w_dy_eff;
    logic [10:0]        w_x_new;
    logic [10:0]        w_y_new;
    jump_state_t        w_state_next;
    logic [RISE_W-1:0]  w_rise_next;
    logic               w_kick_edge;

    assign w_kick_edge = kickon & ~r_kick_prev;

    assign w_x_sum = $signed({2'b00, r_px}) + $signed({{2{dx[10]}}, dx});

    always_comb begin
        w_x_new = w_x_sum[10:0];
`ifdef WRAP_X_EN
        if (w_x_sum < 13'sd0)
            w_x_new = 11'(w_x_sum + X_MAX + 13'sd1);
        else if (w_x_sum > X_MAX)
            w_x_new = 11'(w_x_sum - X_MAX - 13'sd1);
`else
        if (w_x_sum < 13'sd0)
            w_x_new = 11'd0;
        else if (w_x_sum > X_MAX)
            w_x_new = X_MAX[10:0];
`endif
    end

    // Vertical step depends on jump phase; landing/apex transitions use the clamped result.
    always_comb begin
        w_dy_eff     = 11'sd0;
        w_state_next = r_state;
        w_rise_next  = r_rise_cnt;
        case (r_state)
            GROUNDED: begin
                if (dy[10]) begin
                    w_dy_eff     = $signed(dy);
                    w_state_next = RISING;
                    w_rise_next  = RISE_W'(1);
                end
            end
            RISING: begin
                if (dy[10] && (r_rise_cnt < RISE_MAX)) begin
                    w_dy_eff    = $signed(dy);
                    w_rise_next = r_rise_cnt + RISE_W'(1);
                end else begin
                    w_dy_eff     = GRAV;
                    w_state_next = FALLING;
                end
            end
            FALLING: begin
                w_dy_eff = ($signed(dy) > GRAV) ? $signed(dy) : GRAV;
            end
            default: begin
                w_state_next = GROUNDED;
                w_rise_next  = '0;
            end
        endcase

        w_y_sum = $signed({2'b00, r_py}) + $signed({{2{w_dy_eff[10]}}, w_dy_eff});
        if (w_y_sum < 13'sd0)
            w_y_new = 11'd0;
        else if (w_y_sum > Y_MAX)
            w_y_new = Y_MAX[10:0];
        else
            w_y_new = w_y_sum[10:0];

        if (r_state == RISING && w_y_new == 11'd0)
            w_state_next = FALLING;
        if (r_state == FALLING && w_y_new == Y_MAX[10:0]) begin
            w_state_next = GROUNDED;
            w_rise_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= GROUNDED;
            r_tick_cnt    <= '0;
            r_rise_cnt    <= '0;
            r_kick_cnt    <= '0;
            r_kick_prev   <= 1'b0;
            r_px          <= 11'(START_X);
            r_py          <= Y_MAX[10:0];
            r_on_ground   <= 1'b1;
            r_kick_active <= 1'b0;
            r_frame_tick  <= 1'b0;
        end else begin
            r_tick_cnt   <= (r_tick_cnt == CNT_MAX) ? '0 : r_tick_cnt + CNT_W'(1);
            r_frame_tick <= (r_tick_cnt == CNT_MAX);
            r_kick_prev  <= kickon;

            if (r_frame_tick) begin
                r_px        <= w_x_new;
                r_py        <= w_y_new;
                r_state     <= w_state_next;
                r_rise_cnt  <= w_rise_next;
                r_on_ground <= (w_state_next == GROUNDED);
            end

            // A kick that starts on a tick cycle is not decremented by that tick.
            if (!r_kick_active && w_kick_edge) begin
                r_kick_active <= 1'b1;
                r_kick_cnt    <= KICK_INIT;
            end else if (r_kick_active && r_frame_tick) begin
                r_kick_cnt <= r_kick_cnt - KICK_W'(1);
                if (r_kick_cnt == KICK_W'(1))
                    r_kick_active <= 1'b0;
            end
        end
    end

    assign px          = r_px;
    assign py          = r_py;
    assign on_ground   = r_on_ground;
    assign kick_active = r_kick_active;
    assign frame_tick  = r_frame_tick;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_player_motion_integrator.sv
// Directed bench for player_motion_integrator with a 4-cycle frame tick.
module tb_player_motion_integrator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] dx = '0;
    logic [10:0] dy = '0;
    logic        kickon = 1'b0;
    logic [10:0] px;
    logic [10:0] py;
    logic        on_ground;
    logic        kick_active;
    logic        frame_tick;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    player_motion_integrator #(.TICK_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dx          (dx),
        .dy          (dy),
        .kickon      (kickon),
        .px          (px),
        .py          (py),
        .on_ground   (on_ground),
        .kick_active (kick_active),
        .frame_tick  (frame_tick),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Let the current or next frame tick consume the inputs, return one cycle later.
    task automatic tick_wait();
        int n = 0;
        while (frame_tick !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (frame_tick !== 1'b1) begin
            n_cmp++;
            n_err++;
            $error("FAIL tick_timeout: observed %0d expected 1", frame_tick);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [10:0] exp_wrap_neg [4];
        logic [10:0] exp_x;
`ifdef WRAP_X_EN
        exp_wrap_neg = '{11'd1, 11'd0, 11'd608, 11'd607};
`else
        exp_wrap_neg = '{11'd1, 11'd0, 11'd0, 11'd0};
`endif

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_px", px, 304);
        chk("rst_py", py, 368);
        chk("rst_on_ground", on_ground, 1);
        chk("rst_kick", kick_active, 0);
        chk("rst_frame_tick", frame_tick, 0);
        chk("rst_state", state_dbg, 0);
        rst_n = 1'b1;

        // Frame tick every 4th cycle, one cycle wide
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("frame_tick_seq", frame_tick, (i % 4 == 3) ? 1 : 0);
        end

        // Walk right with positive dy while grounded
        dx = 11'd1;
        dy = 11'd5;
        for (int i = 1; i <= 3; i++) begin
            tick_wait();
            chk("walk_px", px, 304 + i);
            chk("walk_py", py, 368);
            chk("walk_on_ground", on_ground, 1);
        end

        // Jump: 10 rising ticks, then gravity until landing
        dx = 11'd0;
        dy = 11'(-5);
        for (int i = 1; i <= 10; i++) begin
            tick_wait();
            chk("rise_py", py, 368 - 5 * i);
            chk("rise_state", state_dbg, 1);
        end
        for (int i = 1; i <= 10; i++) begin
            tick_wait();
            chk("fall_py", py, 318 + 5 * i);
            chk("fall_state", state_dbg, (i < 10) ? 2 : 0);
            chk("fall_on_ground", on_ground, (i < 10) ? 0 : 1);
        end
        dy = 11'd0;

        // Left edge
        dx = 11'(-305);
        tick_wait();
        chk("x_to_2", px, 2);
        dx = 11'h7FF;
        for (int i = 0; i < 4; i++) begin
            tick_wait();
            chk("x_left_edge", px, exp_wrap_neg[i]);
        end

        // Right edge
`ifdef WRAP_X_EN
        dx = 11'(-7);
        exp_x = 11'd1;
`else
        dx = 11'd600;
        exp_x = 11'd608;
`endif
        tick_wait();
        chk("x_to_600", px, 600);
        dx = 11'd10;
        tick_wait();
        chk("x_right_edge", px, exp_x);
        dx = 11'd0;

        // Kick pulse, ignored second pulse, held level after expiry
        kickon = 1'b1;
        @(negedge clk);
        kickon = 1'b0;
        chk("kick_start", kick_active, 1);
        for (int i = 1; i <= 12; i++) begin
            tick_wait();
            if (i == 3) begin
                kickon = 1'b1;
                @(negedge clk);
                kickon = 1'b0;
            end
            if (i == 5) kickon = 1'b1;
            chk("kick_window", kick_active, (i < 12) ? 1 : 0);
        end
        for (int i = 0; i < 2; i++) begin
            tick_wait();
            chk("kick_no_retrigger", kick_active, 0);
        end
        kickon = 1'b0;

        // Kick edge coinciding with a frame tick is not decremented by it
        repeat (3) @(negedge clk);
        chk("tick_align", frame_tick, 1);
        kickon = 1'b1;
        @(negedge clk);
        kickon = 1'b0;
        chk("kick_on_tick_start", kick_active, 1);
        for (int i = 1; i <= 12; i++) begin
            tick_wait();
            chk("kick_on_tick_window", kick_active, (i < 12) ? 1 : 0);
        end

        // Reset mid-jump and mid-kick
        kickon = 1'b1;
        @(negedge clk);
        kickon = 1'b0;
        dy = 11'(-19);
        tick_wait();
        chk("jump2_py", py, 349);
        tick_wait();
        chk("jump2_py", py, 330);
        chk("jump2_state", state_dbg, 1);
        chk("jump2_kick", kick_active, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_py", py, 368);
        chk("mid_rst_px", px, 304);
        chk("mid_rst_on_ground", on_ground, 1);
        chk("mid_rst_state", state_dbg, 0);
        chk("mid_rst_kick", kick_active, 0);
        chk("mid_rst_frame_tick", frame_tick, 0);
        rst_n = 1'b1;
        dy = 11'd0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
